// File: rtl/prog_mem_loader_pkg.sv
// Shared constants for the program memory loader and anything that builds
// instruction words for it (state encoding, NOP, opcodes used by the core).
package prog_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Where the fetch output currently comes from.
    typedef enum logic [1:0] {
        FS_ZERO = 2'd0,
        FS_NOP  = 2'd1,
        FS_MEM  = 2'd2
    } fetch_src_t;

    // addi x0,x0,0
    localparam logic [31:0] RV_NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, OPC_LUI};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, OPC_JALR};
    endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// XLEN x DEPTH synchronous RAM, one write port and one read port.
// No reset on the array or the read register so it maps onto block RAM.
module prog_mem_ram #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Write port and registered read port; read data holds when re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Instruction memory with a streaming load port. After reset the memory is
// optionally cleared, a program is streamed in, then the core is released
// and fetches are served from the RAM.
//
// state    | meaning
// ST_CLEAR | writing FILL_WORD to every word, one per cycle
// ST_IDLE  | waiting for load_start
// ST_LOAD  | accepting program beats at ptr
// ST_RUN   | core released, fetches read memory
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              DEPTH          = 1024,
    parameter logic [XLEN-1:0] FILL_WORD      = '0,
    parameter logic [XLEN-1:0] NOP_WORD       = RV_NOP_WORD,
    parameter bit              CLEAR_ON_RESET = 1'b1,
    localparam int             ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [XLEN-1:0]   load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [XLEN-1:0]   fetch_data,
    output logic              cpu_run,
    output logic              busy,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow
);

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              ovf_q;
    fetch_src_t        fsrc_q;
    logic              ptr_last;
    logic              mem_we;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_re;
    logic [XLEN-1:0]   mem_rdata;

    assign ptr_last = (ptr_q == ADDR_W'(DEPTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a restart in LOAD takes priority over any beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (ptr_last) state_d = ST_IDLE;
            ST_IDLE:  if (load_start) state_d = ST_LOAD;
            ST_LOAD:  if (!load_start && load_valid && (load_last || ptr_last)) state_d = ST_RUN;
            ST_RUN:   if (load_start) state_d = ST_LOAD;
            default:  state_d = RST_STATE;
        endcase
    end

    // Outputs decoded from registered state, plus RAM write/read controls.
    always_comb begin
        load_ready = (state_q == ST_LOAD);
        busy       = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
        cpu_run    = (state_q == ST_RUN);
        mem_we     = (state_q == ST_CLEAR) ||
                     ((state_q == ST_LOAD) && load_valid && !load_start);
        mem_wdata  = (state_q == ST_CLEAR) ? FILL_WORD : load_data;
        mem_re     = fetch_en && (state_q == ST_RUN);
    end

    // Write pointer, beat counter and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: ptr_q <= ptr_q + ADDR_W'(1);
                ST_LOAD: begin
                    if (load_start) begin
                        ptr_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                    end else if (load_valid) begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                        cnt_q <= cnt_q + (ADDR_W + 1)'(1);
                        if (ptr_last && !load_last) ovf_q <= 1'b1;
                    end
                end
                default: begin
                    if (load_start) begin
                        ptr_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Remember what the last accepted fetch should return; held while fetch_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsrc_q <= FS_ZERO;
        end else if (fetch_en) begin
            fsrc_q <= (state_q == ST_RUN) ? FS_MEM : FS_NOP;
        end
    end

    // Fetch output mux over registered sources.
    always_comb begin
        case (fsrc_q)
            FS_MEM:  fetch_data = mem_rdata;
            FS_NOP:  fetch_data = NOP_WORD;
            default: fetch_data = '0;
        endcase
    end

    assign load_count = cnt_q;
    assign overflow   = ovf_q;

    prog_mem_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ptr_q),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (fetch_addr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader with DEPTH=16: clear, load, overflow, restart
// and reset-mid-load sequences, with a fetch scoreboard against a memory model.
module tb_prog_mem_loader;
    import prog_mem_loader_pkg::*;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] FILL  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start, load_valid, load_last;
    logic [31:0]   load_data;
    logic          load_ready;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_data;
    logic          cpu_run, busy;
    logic [AW:0]   load_count;
    logic          overflow;

    prog_mem_loader #(
        .XLEN           (32),
        .DEPTH          (DEPTH),
        .FILL_WORD      (FILL),
        .NOP_WORD       (NOP),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .load_count (load_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        int          exp_cnt;
        logic        exp_run;
    } beat_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q [$];
    beat_t       vec [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after negedge; outputs are sampled at the next negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_check(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, fetch_data, e);
        end
    endtask

    task automatic fetch_one(input logic [AW-1:0] a, input logic [31:0] e, input string name);
        fetch_en   = 1'b1;
        fetch_addr = a;
        exp_q.push_back(e);
        step();
        fetch_en = 1'b0;
        sb_check(name);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int          n;
        logic [31:0] w0, w1, w2;

        w0 = enc_lui(5'd1, 20'h0001f);
        w1 = enc_lui(5'd2, 20'h000f1);
        w2 = enc_jalr(5'd0, 5'd0, 12'h000);
        vec[0] = '{1'b1, w0,           1'b0, 1, 1'b0};
        vec[1] = '{1'b0, 32'hBAD0BAD0, 1'b0, 1, 1'b0};
        vec[2] = '{1'b1, w1,           1'b0, 2, 1'b0};
        vec[3] = '{1'b0, 32'hBAD1BAD1, 1'b1, 2, 1'b0};
        vec[4] = '{1'b1, w2,           1'b1, 3, 1'b1};
        for (int i = 0; i < DEPTH; i++) model_mem[i] = FILL;

        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = '0; fetch_en = 1'b0; fetch_addr = '0;
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_run", {31'b0, cpu_run}, 32'd0);
        chk("rst_ready", {31'b0, load_ready}, 32'd0);
        chk("rst_count", {27'b0, load_count}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_fetch", fetch_data, 32'd0);

        // CLEAR: fetch returns NOP, load_start ignored, busy lasts DEPTH cycles.
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        fetch_one(4'd5, NOP, "clear_fetch_nop");
        pulse_start();
        wait_clear(n);
        chk("clear_len", n + 2, DEPTH);
        chk("idle_ready", {31'b0, load_ready}, 32'd0);
        chk("idle_run", {31'b0, cpu_run}, 32'd0);
        fetch_one(4'd5, NOP, "idle_fetch_nop");

        // Program load with gaps; a last flag without valid must be ignored.
        pulse_start();
        chk("load_ready", {31'b0, load_ready}, 32'd1);
        chk("load_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            load_valid = vec[i].valid;
            load_data  = vec[i].data;
            load_last  = vec[i].last;
            step();
            chk($sformatf("vec%0d_count", i), {27'b0, load_count}, vec[i].exp_cnt);
            chk($sformatf("vec%0d_run", i), {31'b0, cpu_run}, {31'b0, vec[i].exp_run});
        end
        load_valid = 1'b0; load_last = 1'b0;
        model_mem[0] = w0; model_mem[1] = w1; model_mem[2] = w2;
        chk("run_ready", {31'b0, load_ready}, 32'd0);
        chk("run_busy", {31'b0, busy}, 32'd0);

        // Back-to-back fetches through the scoreboard, then hold.
        for (int i = 0; i < 4; i++) begin
            fetch_en   = 1'b1;
            fetch_addr = AW'(i);
            exp_q.push_back(model_mem[i]);
            step();
            sb_check($sformatf("prog_fetch%0d", i));
        end
        fetch_en   = 1'b0;
        fetch_addr = 4'd0;
        step();
        chk("fetch_hold", fetch_data, model_mem[3]);

        // Overflow: DEPTH beats with no last.
        pulse_start();
        chk("reload_run_drop", {31'b0, cpu_run}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            beat(32'h1000_0000 + i, 1'b0);
            model_mem[i] = 32'h1000_0000 + i;
            chk($sformatf("ovf_cnt%0d", i), {27'b0, load_count}, i + 1);
            chk($sformatf("ovf_flag%0d", i), {31'b0, overflow}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
            chk($sformatf("ovf_run%0d", i), {31'b0, cpu_run}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        fetch_one(4'd15, model_mem[15], "ovf_fetch15");

        // Two-word reload clears overflow.
        pulse_start();
        chk("reload_ovf_clr", {31'b0, overflow}, 32'd0);
        chk("reload_cnt_clr", {27'b0, load_count}, 32'd0);
        beat(32'hC0DE_0000, 1'b0);
        beat(w2, 1'b1);
        model_mem[0] = 32'hC0DE_0000; model_mem[1] = w2;
        chk("reload_cnt", {27'b0, load_count}, 32'd2);
        chk("reload_ovf", {31'b0, overflow}, 32'd0);
        chk("reload_run", {31'b0, cpu_run}, 32'd1);
        fetch_one(4'd1, model_mem[1], "reload_fetch1");
        fetch_one(4'd2, model_mem[2], "reload_fetch2");

        // load_start coinciding with beat 2 discards that beat.
        pulse_start();
        beat(32'hAAAA_0001, 1'b0);
        model_mem[0] = 32'hAAAA_0001;
        load_start = 1'b1;
        beat(32'hBBBB_0002, 1'b0);
        load_start = 1'b0;
        chk("restart_cnt", {27'b0, load_count}, 32'd0);
        chk("restart_ready", {31'b0, load_ready}, 32'd1);
        beat(32'hCCCC_0003, 1'b1);
        model_mem[0] = 32'hCCCC_0003;
        chk("restart_cnt2", {27'b0, load_count}, 32'd1);
        fetch_one(4'd0, model_mem[0], "restart_fetch0");
        fetch_one(4'd1, model_mem[1], "restart_fetch1");

        // Async reset during beat 4 of a load.
        pulse_start();
        for (int i = 0; i < 3; i++) beat(32'hEEEE_0000 + i, 1'b0);
        load_valid = 1'b1;
        load_data  = 32'hEEEE_0003;
        rst_n      = 1'b0;
        #1;
        chk("midrst_run", {31'b0, cpu_run}, 32'd0);
        chk("midrst_ready", {31'b0, load_ready}, 32'd0);
        chk("midrst_count", {27'b0, load_count}, 32'd0);
        chk("midrst_fetch", fetch_data, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd1);
        load_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        wait_clear(n);
        chk("clear2_len", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = FILL;
        pulse_start();
        beat(32'hD00D_0001, 1'b1);
        model_mem[0] = 32'hD00D_0001;
        chk("postrst_cnt", {27'b0, load_count}, 32'd1);
        chk("postrst_run", {31'b0, cpu_run}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            fetch_en   = 1'b1;
            fetch_addr = AW'(i);
            exp_q.push_back(model_mem[i]);
            step();
            sb_check($sformatf("postrst_fetch%0d", i));
        end
        fetch_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Parametrised instruction memory for the riscv core, replacing hierarchical preloading of program memory with a synthesizable load port.
- Clears memory to a fill word after reset, then accepts a program as a valid/ready word stream.
- Releases the core (cpu_run) once the program is loaded, and serves synchronous instruction fetches.
- Sits between the external loader (UART/testbench) and the core's fetch port.

Parameters:
XLEN, 32, instruction/data word width
DEPTH, 1024, number of words (power of two, >=4)
FILL_WORD, 32'h0000_0000, value written to every word during CLEAR
NOP_WORD, 32'h0000_0013, word returned on fetch while cpu_run is low (addi x0,x0,0)
CLEAR_ON_RESET, 1, 1: run CLEAR after reset; 0: go straight to IDLE
ADDR_W, $clog2(DEPTH), derived localparam, not overridable

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: begin a new program load at word 0
load_valid  in  1  load_data is valid this cycle
load_data  in  XLEN  program word
load_last  in  1  qualifies the final beat of the program
load_ready  out  1  high only in LOAD
fetch_en  in  1  fetch request
fetch_addr  in  ADDR_W  word address (byte address >> 2)
fetch_data  out  XLEN  registered fetch result
cpu_run  out  1  core may execute; high only in RUN
busy  out  1  high in CLEAR or LOAD
load_count  out  ADDR_W+1  words written by the current/last load
overflow  out  1  sticky: load hit DEPTH words without load_last

Behaviour:
- Reset (async, rst_n low):
  - State goes to CLEAR if CLEAR_ON_RESET, else IDLE.
  - All outputs are 0: fetch_data=0, cpu_run=0, load_ready=0, load_count=0, overflow=0; busy=CLEAR_ON_RESET.
  - Memory array is not reset.
- FSM states: CLEAR, IDLE, LOAD, RUN.
- CLEAR:
  - Writes FILL_WORD at pointer 0..DEPTH-1, one word per cycle (DEPTH cycles), then moves to IDLE.
  - load_start is ignored. Fetches return NOP_WORD.
- IDLE: load_start -> LOAD next cycle with pointer=0, load_count=0, overflow cleared.
- LOAD:
  - A beat is load_valid && load_ready: writes mem[ptr]=load_data, then ptr++ and load_count++.
  - Beat with load_last -> RUN next cycle.
  - Beat at ptr==DEPTH-1 without load_last -> word written, overflow=1, RUN next cycle.
  - load_start asserted in LOAD restarts: ptr=0, load_count=0, overflow cleared. Any beat in that same cycle is discarded (not written, not counted).
- RUN:
  - cpu_run=1.
  - load_start -> LOAD next cycle; cpu_run drops in that same transition.
  - load_count and overflow hold their values.
- Fetch:
  - 1-cycle latency. If fetch_en is high at edge N, fetch_data after edge N = mem[fetch_addr] when the state at edge N is RUN, else NOP_WORD.
  - fetch_en low holds fetch_data.
- Memory has a single write port (CLEAR/LOAD) and a single read port. No read-during-write hazard, since fetch reads memory only in RUN and writes only occur outside RUN.
- cpu_run, busy and load_ready are decoded from registered state (glitch-free). No combinational path from load_valid to load_ready.
- Async reset mid-LOAD or mid-CLEAR aborts the operation. Partially written memory content is left as is and overwritten by CLEAR if enabled.

Decomposition:
- Shared package: state encoding constants (ST_CLEAR/ST_IDLE/ST_LOAD/ST_RUN), NOP_WORD, and opcode defines already used by the core (LUI, JALR), so benches build words from a single source.
- One sub-module: prog_mem_ram, a parametrised XLEN x DEPTH synchronous single-write/single-read RAM (inferable BRAM). FSM, pointer and fetch muxing stay in prog_mem_loader.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=16 -> busy high exactly 16 cycles, then IDLE; fetch at addr 5 returns 32'h13; cpu_run=0.
- Load 3 words {lui x1,0x1f; lui x2,0xf1; jalr x0,0(x0)} with last on beat 3 -> cpu_run=1 next cycle, load_count=3; fetch addr 0/1/2 returns those words one cycle later; addr 3 returns 0.
- load_valid toggling every other cycle during LOAD -> only handshaked beats are written; load_count equals the number of valid cycles.
- DEPTH=16, stream 16 words with no load_last -> overflow=1, load_count=16, RUN entered. A following 2-word reload clears overflow and load_count=2.
- load_start during beat 2 of a load -> that beat is discarded, ptr restarts at 0; the next beat lands at addr 0.
- rst_n low mid-LOAD (beat 4) -> all outputs 0 immediately; CLEAR reruns; addr 0..3 read FILL_WORD after a subsequent 1-word load to addr 0 (addr 0 = new word).
